// File: rtl/dso_la_pkg.sv
// Shared definitions for the DSO/LA capture path: sample width, default buffer
// address width and the sample_reader state encoding.
// Build option: SAMPLE_READER_CHKSUM_EN adds the checksum state.
package dso_la_pkg;

    localparam int unsigned AwDefault = 18;
    localparam int unsigned SampleW   = 8;

    typedef logic [2:0] state_t;

    localparam state_t StIdle    = 3'd0;
    localparam state_t StAccess  = 3'd1;
    localparam state_t StPresent = 3'd2;
    localparam state_t StStep    = 3'd3;
`ifdef SAMPLE_READER_CHKSUM_EN
    localparam state_t StCsum    = 3'd4;
`endif

endpackage

// File: rtl/rd_cnt_dn.sv
// Remaining-sample down counter: load, saturating decrement, zero/one flags.
module rd_cnt_dn #(
    parameter int unsigned W = 19
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o,
    output logic         one_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Next count: load has priority over decrement; never wrap below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
    assign one_o  = (cnt_q == W'(1));

endmodule

// File: rtl/sample_reader.sv
// Sample buffer readout: walks the SRAM through the external address generator,
// presents each byte on a valid/ready stream and reports completion.
// Build option: SAMPLE_READER_CHKSUM_EN appends a mod-256 checksum beat.
module sample_reader
    import dso_la_pkg::*;
#(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned AW     = AwDefault
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               start,
    input  logic               abort,
    input  logic               wr_end,
    input  logic [AW:0]        rd_count,
    input  logic [7:0]         rd_step_cfg,
    input  logic [SampleW-1:0] sram_dq,
    output logic               sram_oe,
    output logic               rd_inc,
    output logic [7:0]         rd_step,
    output logic [SampleW-1:0] dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] TmrLast = 3'(RD_LAT - 1);

    state_t               state_q, state_d;
    logic [2:0]           tmr_q, tmr_d;
    logic [SampleW-1:0]   dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;
    logic [7:0]           rd_step_q, rd_step_d;
    logic                 done_q, done_d;
    logic                 cnt_load, cnt_dec, cnt_zero, cnt_one;
    logic                 accept, cancel;
`ifdef SAMPLE_READER_CHKSUM_EN
    logic [SampleW-1:0]   sum_q, sum_d;
`endif

    assign accept = dout_valid_q & dout_ready;
    // wr_end can only be low here after falling, since readout requires it high.
    assign cancel = abort | ~wr_end;

    rd_cnt_dn #(
        .W (AW + 1)
    ) u_rd_cnt_dn (
        .clk        (clk),
        .nrst       (nrst),
        .load_i     (cnt_load),
        .load_val_i (rd_count),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero),
        .one_o      (cnt_one)
    );

    // Next-state logic for the readout FSM, latency timer and output beat.
    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        rd_step_d    = rd_step_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;
`ifdef SAMPLE_READER_CHKSUM_EN
        sum_d        = sum_q;
`endif
        case (state_q)
            StIdle: begin
                if (start && wr_end && !abort) begin
                    cnt_load  = 1'b1;
                    rd_step_d = rd_step_cfg;
                    tmr_d     = '0;
`ifdef SAMPLE_READER_CHKSUM_EN
                    sum_d     = '0;
`endif
                    if (rd_count != '0) begin
                        state_d = StAccess;
                    end else begin
`ifdef SAMPLE_READER_CHKSUM_EN
                        state_d      = StCsum;
                        dout_d       = '0;
                        dout_valid_d = 1'b1;
`else
                        done_d       = 1'b1;
`endif
                    end
                end
            end
            StAccess: begin
                // sram_oe has been high RD_LAT cycles when the timer hits its last value.
                if (tmr_q == TmrLast) begin
                    dout_d       = sram_dq;
                    dout_valid_d = 1'b1;
                    tmr_d        = '0;
                    state_d      = StPresent;
                end else begin
                    tmr_d = tmr_q + 3'd1;
                end
            end
            StPresent: begin
                if (accept) begin
                    dout_valid_d = 1'b0;
`ifdef SAMPLE_READER_CHKSUM_EN
                    sum_d        = sum_q + dout_q;
`endif
                    state_d      = StStep;
                end
            end
            StStep: begin
                cnt_dec = 1'b1;
                // Decision uses the pre-decrement count: one left means this was the last.
                if (cnt_one || cnt_zero) begin
`ifdef SAMPLE_READER_CHKSUM_EN
                    state_d      = StCsum;
                    dout_d       = sum_q;
                    dout_valid_d = 1'b1;
`else
                    state_d      = StIdle;
                    done_d       = 1'b1;
`endif
                end else begin
                    tmr_d   = '0;
                    state_d = StAccess;
                end
            end
`ifdef SAMPLE_READER_CHKSUM_EN
            StCsum: begin
                if (accept) begin
                    dout_valid_d = 1'b0;
                    state_d      = StIdle;
                    done_d       = 1'b1;
                end
            end
`endif
            default: begin
                state_d      = StIdle;
                dout_valid_d = 1'b0;
            end
        endcase

        // Abort or loss of the captured buffer drops everything in flight.
        if ((state_q != StIdle) && cancel) begin
            state_d      = StIdle;
            dout_valid_d = 1'b0;
            done_d       = 1'b0;
            tmr_d        = '0;
            cnt_dec      = 1'b0;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= StIdle;
            tmr_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            rd_step_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            rd_step_q    <= rd_step_d;
            done_q       <= done_d;
        end
    end

`ifdef SAMPLE_READER_CHKSUM_EN
    // Running checksum of accepted sample beats.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end
`endif

    // Moore outputs decoded from the current state.
    always_comb begin
        sram_oe = (state_q == StAccess);
        rd_inc  = (state_q == StStep);
        busy    = (state_q != StIdle);
`ifdef SAMPLE_READER_CHKSUM_EN
        dout_last = (state_q == StCsum);
`else
        dout_last = (state_q == StPresent) && cnt_one;
`endif
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign rd_step    = rd_step_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sample_reader.sv
// Scoreboard bench for sample_reader with a behavioural SRAM/address model.
module tb_sample_reader;

    localparam int RdLat = 2;
    localparam int Aw    = 4;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        wr_end = 1'b1;
    logic [Aw:0] rd_count = '0;
    logic [7:0]  rd_step_cfg = 8'h00;
    logic [7:0]  sram_dq;
    logic        sram_oe, rd_inc, dout_valid, dout_last, busy, done;
    logic [7:0]  rd_step, dout;
    logic        dout_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_reader #(
        .RD_LAT (RdLat),
        .AW     (Aw)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .start       (start),
        .abort       (abort),
        .wr_end      (wr_end),
        .rd_count    (rd_count),
        .rd_step_cfg (rd_step_cfg),
        .sram_dq     (sram_dq),
        .sram_oe     (sram_oe),
        .rd_inc      (rd_inc),
        .rd_step     (rd_step),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout_last   (dout_last),
        .busy        (busy),
        .done        (done)
    );

    // External SRAM and address generator.
    logic [7:0] mem [256];
    logic [7:0] addr = 8'h00;
    logic [7:0] base_addr = 8'h00;
    assign sram_dq = mem[addr];

    always @(posedge clk) begin
        if (start && wr_end && !abort && !busy) addr <= base_addr;
        else if (rd_inc) addr <= addr + rd_step;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Consumer: 0 = always ready, 1 = random, 2 = stalled.
    int rdy_mode = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ($urandom_range(0, 3) != 0);
            default: dout_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state.
    beat_t      exp_q[$];
    int         inc_times[$];
    int         done_cnt = 0;
    logic [7:0] exp_step = 8'h00;
    logic       hold_pend = 1'b0;
    logic [7:0] held_dout = 8'h00;
    logic       done_prev = 1'b0;

    // Monitor: compares every accepted beat and watches stream/step invariants.
    always @(negedge clk or negedge nrst) begin
        beat_t e;
        if (!nrst) begin
            hold_pend = 1'b0;
            done_prev = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                check("done_one_cycle", {31'd0, done_prev}, 32'd0);
            end
            done_prev = done;
            if (rd_inc) inc_times.push_back(cyc);
            if (busy) check("rd_step_stable", {24'd0, rd_step}, {24'd0, exp_step});
            if (hold_pend) begin
                check("hold_valid", {31'd0, dout_valid}, 32'd1);
                check("hold_data", {24'd0, dout}, {24'd0, held_dout});
                check("hold_no_inc", {31'd0, rd_inc}, 32'd0);
            end
            hold_pend = dout_valid && !dout_ready && !abort && wr_end;
            held_dout = dout;
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h, expected no beat", dout);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", {24'd0, dout}, {24'd0, e.data});
                    check("beat_last", {31'd0, dout_last}, {31'd0, e.last});
                end
            end
        end
    end

    // Reference model: the n samples at base + k*step, then the checksum if enabled.
    task automatic push_expected(input int n, input logic [7:0] step, input logic [7:0] base);
        beat_t b;
        int    sum;
        logic [7:0] a;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            a      = 8'(int'(base) + k * int'($signed(step)));
            b.data = mem[a];
            sum    = sum + int'(mem[a]);
`ifdef SAMPLE_READER_CHKSUM_EN
            b.last = 1'b0;
`else
            b.last = (k == n - 1);
`endif
            exp_q.push_back(b);
        end
`ifdef SAMPLE_READER_CHKSUM_EN
        b.data = 8'(sum % 256);
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    task automatic issue_start(input int n, input logic [7:0] step, input logic [7:0] base);
        @(posedge clk);
        #1;
        base_addr   = base;
        rd_count    = (Aw + 1)'(n);
        rd_step_cfg = step;
        exp_step    = step;
        inc_times.delete();
        push_expected(n, step, base);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("done_seen", {31'd0, done_cnt != d0}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sram_oe"}, {31'd0, sram_oe}, 32'd0);
        check({tag, "_rd_inc"}, {31'd0, rd_inc}, 32'd0);
        check({tag, "_dout_valid"}, {31'd0, dout_valid}, 32'd0);
        check({tag, "_dout_last"}, {31'd0, dout_last}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_dout"}, {24'd0, dout}, 32'd0);
        check({tag, "_rd_step"}, {24'd0, rd_step}, 32'd0);
    endtask

    // Full readout; hold stalls the first beat for 10 cycles, poke tries a start while busy.
    task automatic run_readout(input int n, input logic [7:0] step, input logic [7:0] base,
                               input int mode, input bit hold, input bit poke);
        int d0;
        int i;
        rdy_mode = hold ? 2 : mode;
        d0 = done_cnt;
        issue_start(n, step, base);
        if (n == 0) begin
            check("zero_step_latched", {24'd0, rd_step}, {24'd0, step});
`ifndef SAMPLE_READER_CHKSUM_EN
            check("zero_done_next_cycle", {31'd0, done}, 32'd1);
            check("zero_no_beat", {31'd0, dout_valid}, 32'd0);
`endif
        end else begin
            i = 0;
            while (!dout_valid && i < 20) begin
                @(posedge clk);
                #1;
                i++;
            end
            check("first_latency", i, RdLat);
            if (poke) begin
                start       = 1'b1;
                rd_step_cfg = ~step;
                rd_count    = (Aw + 1)'(7);
                @(posedge clk);
                #1;
                start       = 1'b0;
                rd_step_cfg = step;
            end
            if (hold) begin
                repeat (10) @(negedge clk);
                check("stall_valid", {31'd0, dout_valid}, 32'd1);
                check("stall_no_inc", inc_times.size(), 0);
                rdy_mode = mode;
            end
        end
        wait_done(d0);
        check("inc_count", inc_times.size(), n);
        check("queue_empty", exp_q.size(), 0);
        if (mode == 0 && !hold) begin
            for (int k = 1; k < inc_times.size(); k++) begin
                check("inc_gap", inc_times[k] - inc_times[k-1], RdLat + 2);
            end
        end
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int viol;
        int t;
        for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
        #3;
        check_reset_outputs("reset");
        #10;
        nrst = 1'b1;

        // Directed three-sample readout.
        mem[8'h40] = 8'h11;
        mem[8'h41] = 8'h22;
        mem[8'h42] = 8'h33;
        run_readout(3, 8'h01, 8'h40, 0, 1'b0, 1'b1);

        // start with the buffer not full is ignored.
        @(posedge clk);
        #1;
        wr_end   = 1'b0;
        rd_count = (Aw + 1)'(3);
        inc_times.delete();
        d0    = done_cnt;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        viol  = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy || sram_oe || rd_inc || done) viol++;
        end
        check("wr_end_low_ignored", viol, 0);
        check("wr_end_low_no_done", done_cnt - d0, 0);
        wr_end = 1'b1;

        // Consumer stall in the first beat.
        run_readout(2, 8'h03, 8'h10, 0, 1'b1, 1'b0);

        // Abort in the second access.
        rdy_mode = 0;
        d0 = done_cnt;
        issue_start(5, 8'h01, 8'h80);
        t = 0;
        while (inc_times.size() == 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        abort = 1'b1;
        check("abort_in_access", {31'd0, sram_oe}, 32'd1);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, dout_valid}, 32'd0);
        check("abort_oe", {31'd0, sram_oe}, 32'd0);
        check("abort_beats_left", exp_q.size(), 4 + ((`ifdef SAMPLE_READER_CHKSUM_EN 1 `else 0 `endif)));
        exp_q.delete();
        repeat (20) @(negedge clk);
        check("abort_inc_count", inc_times.size(), 1);
        check("abort_no_done", done_cnt - d0, 0);

        // Empty readout with a negative step.
        run_readout(0, 8'hFE, 8'h00, 0, 1'b0, 1'b0);

        // Asynchronous reset while presenting, then a clean readout.
        rdy_mode = 2;
        issue_start(3, 8'h02, 8'h20);
        t = 0;
        while (!dout_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("pre_reset_valid", {31'd0, dout_valid}, 32'd1);
        @(negedge clk);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        exp_q.delete();
        #3;
        nrst     = 1'b1;
        rdy_mode = 0;
        run_readout(4, 8'h05, 8'h30, 0, 1'b0, 1'b0);

        // Full buffer and single sample boundaries.
        run_readout(16, 8'h01, 8'hF8, 0, 1'b0, 1'b0);
        run_readout(1, 8'h7F, 8'h55, 1, 1'b0, 1'b0);

        // Randomised readouts.
        for (int r = 0; r < 20; r++) begin
            run_readout($urandom_range(0, 16), 8'($urandom), 8'($urandom),
                        $urandom_range(0, 1), 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
